// File: rtl/uart_rx_data_sampler.sv
// UART receiver oversampling front end: per-bit edge counter, per-frame bit counter, mid-bit sampler.
// Define SAMPLER_MAJORITY_EN for a 3-sample majority vote; otherwise a single mid-bit sample is taken.
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cnt_en,
  input  logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  logic [PRESCALE_W-1:0] pe_s;
  logic [PRESCALE_W-1:0] mid_s;
  logic [PRESCALE_W-1:0] pe_last_s;
  logic                  edge_wrap_s;
  logic                  vote_s;
  logic                  vote_bit_s;

  // effective ratio (floored at 4), mid-bit index, wrap and vote detection
  always_comb begin
    pe_s = prescale;
    if (prescale < PRESCALE_W'(4)) begin
      pe_s = PRESCALE_W'(4);
    end else begin
      pe_s = prescale;
    end
    mid_s       = pe_s >> 1;
    pe_last_s   = pe_s - PRESCALE_W'(1);
    // >= rather than == so a shrunken prescale cannot strand the counter above the wrap point
    edge_wrap_s = (edge_cnt >= pe_last_s);
    vote_s      = dat_samp_en && (edge_cnt == mid_s);
  end

  // edge and bit counters, held at zero while counting is disabled
  always_ff @(posedge CLK) begin
    if (RST || !cnt_en) begin
      edge_cnt <= {PRESCALE_W{1'b0}};
      bit_cnt  <= {BIT_CNT_W{1'b0}};
    end else if (edge_wrap_s) begin
      edge_cnt <= {PRESCALE_W{1'b0}};
      bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

`ifdef SAMPLER_MAJORITY_EN
  logic s0_r;
  logic s1_r;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // pre-samples two and one edges ahead of mid-bit; idle-high after reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_r <= 1'b1;
      s1_r <= 1'b1;
    end else if (dat_samp_en) begin
      if (edge_cnt == (mid_s - PRESCALE_W'(2))) begin
        s0_r <= RX_IN;
      end
      if (edge_cnt == (mid_s - PRESCALE_W'(1))) begin
        s1_r <= RX_IN;
      end
    end
  end

  assign vote_bit_s = majority3(s0_r, s1_r, RX_IN);
`else
  assign vote_bit_s = RX_IN;
`endif

  // resolved bit and its one-cycle strobe; reset discards any pending vote
  always_ff @(posedge CLK) begin
    if (RST) begin
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else if (vote_s) begin
      sampled_bit  <= vote_bit_s;
      sample_valid <= 1'b1;
    end else begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Directed self-checking bench for uart_rx_data_sampler; honours SAMPLER_MAJORITY_EN for glitch expectations.
module tb_uart_rx_data_sampler;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       cnt_en;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  int total = 0;
  int bad   = 0;

  uart_rx_data_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .CLK(clk), .RST(rst), .RX_IN(rx_in), .prescale(prescale),
    .cnt_en(cnt_en), .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt), .sampled_bit(sampled_bit), .sample_valid(sample_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    cnt_en      = 1'b0;
    dat_samp_en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt_en = 1'b1; dat_samp_en = 1'b1; rx_in = 1'b0; prescale = 6'd8;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (edge_cnt !== 6'd0) begin bad++; $display("FAIL reset_edge cyc=%0d got=%0d exp=0", i, edge_cnt); end
      total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL reset_bit cyc=%0d got=%0d exp=0", i, bit_cnt); end
      total++; if (sampled_bit !== 1'b1) begin bad++; $display("FAIL reset_sampled cyc=%0d got=%b exp=1", i, sampled_bit); end
      total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, sample_valid); end
    end
    rst = 1'b0;
    go_idle();
  endtask

  task automatic test_clean_frame();
    logic [0:9] frame_v;
    logic       exp_v;
    int         strobes;
    frame_v = 10'b0101100101;
    strobes = 0;
    prescale = 6'd8; cnt_en = 1'b1; dat_samp_en = 1'b1;
    for (int s = 0; s < 80; s++) begin
      exp_v = ((s % 8) == 5) ? 1'b1 : 1'b0;
      total++; if (edge_cnt !== 6'(s % 8)) begin bad++; $display("FAIL frame_edge s=%0d got=%0d exp=%0d", s, edge_cnt, s % 8); end
      total++; if (bit_cnt !== 4'(s / 8)) begin bad++; $display("FAIL frame_bitcnt s=%0d got=%0d exp=%0d", s, bit_cnt, s / 8); end
      total++; if (sample_valid !== exp_v) begin bad++; $display("FAIL frame_valid s=%0d got=%b exp=%b", s, sample_valid, exp_v); end
      if (sample_valid === 1'b1) strobes++;
      if (exp_v) begin
        total++; if (sampled_bit !== frame_v[s / 8]) begin bad++; $display("FAIL frame_bit idx=%0d got=%b exp=%b", s / 8, sampled_bit, frame_v[s / 8]); end
      end
      rx_in = frame_v[s / 8];
      step();
    end
    total++; if (strobes != 10) begin bad++; $display("FAIL frame_strobes got=%0d exp=10", strobes); end
    go_idle();
  endtask

  task automatic test_glitch();
    int   glitch_at;
    logic exp_bit;
`ifdef SAMPLER_MAJORITY_EN
    glitch_at = 16 + 7;
    exp_bit   = 1'b0;
`else
    glitch_at = 16 + 8;
    exp_bit   = 1'b1;
`endif
    prescale = 6'd16; rx_in = 1'b0; cnt_en = 1'b1; dat_samp_en = 1'b1;
    for (int s = 0; s < 32; s++) begin
      total++; if (edge_cnt !== 6'(s % 16)) begin bad++; $display("FAIL glitch_edge s=%0d got=%0d exp=%0d", s, edge_cnt, s % 16); end
      if (s == 9 || s == 25) begin
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL glitch_valid s=%0d got=%b exp=1", s, sample_valid); end
      end
      if (s == 9) begin
        total++; if (sampled_bit !== 1'b0) begin bad++; $display("FAIL glitch_clean got=%b exp=0", sampled_bit); end
      end
      if (s == 25) begin
        total++; if (sampled_bit !== exp_bit) begin bad++; $display("FAIL glitch_bit got=%b exp=%b", sampled_bit, exp_bit); end
      end
      rx_in = (s == glitch_at) ? 1'b1 : 1'b0;
      step();
    end
    rx_in = 1'b0;
    go_idle();
  endtask

  task automatic test_prescale();
    logic exp_v;
    prescale = 6'd2; rx_in = 1'b0; cnt_en = 1'b1; dat_samp_en = 1'b1;
    for (int s = 0; s < 12; s++) begin
      exp_v = ((s % 4) == 3) ? 1'b1 : 1'b0;
      total++; if (edge_cnt !== 6'(s % 4)) begin bad++; $display("FAIL p2_edge s=%0d got=%0d exp=%0d", s, edge_cnt, s % 4); end
      total++; if (sample_valid !== exp_v) begin bad++; $display("FAIL p2_valid s=%0d got=%b exp=%b", s, sample_valid, exp_v); end
      if (exp_v) begin
        total++; if (sampled_bit !== 1'b0) begin bad++; $display("FAIL p2_bit s=%0d got=%b exp=0", s, sampled_bit); end
      end
      step();
    end
    go_idle();
    prescale = 6'd9; rx_in = 1'b1; cnt_en = 1'b1; dat_samp_en = 1'b1;
    for (int s = 0; s < 18; s++) begin
      exp_v = ((s % 9) == 5) ? 1'b1 : 1'b0;
      total++; if (edge_cnt !== 6'(s % 9)) begin bad++; $display("FAIL p9_edge s=%0d got=%0d exp=%0d", s, edge_cnt, s % 9); end
      total++; if (sample_valid !== exp_v) begin bad++; $display("FAIL p9_valid s=%0d got=%b exp=%b", s, sample_valid, exp_v); end
      if (exp_v) begin
        total++; if (sampled_bit !== 1'b1) begin bad++; $display("FAIL p9_bit s=%0d got=%b exp=1", s, sampled_bit); end
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_enables();
    prescale = 6'd8; rx_in = 1'b0; cnt_en = 1'b1; dat_samp_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL nosamp_valid cyc=%0d got=%b exp=0", i, sample_valid); end
      total++; if (sampled_bit !== 1'b1) begin bad++; $display("FAIL nosamp_hold cyc=%0d got=%b exp=1", i, sampled_bit); end
    end
    total++; if (bit_cnt !== 4'd1) begin bad++; $display("FAIL nosamp_bitcnt got=%0d exp=1", bit_cnt); end
    for (int i = 0; i < 5; i++) step();
    total++; if (edge_cnt !== 6'd5) begin bad++; $display("FAIL cnt_drop_pre got=%0d exp=5", edge_cnt); end
    cnt_en = 1'b0;
    step();
    total++; if (edge_cnt !== 6'd0) begin bad++; $display("FAIL cnt_drop_edge got=%0d exp=0", edge_cnt); end
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL cnt_drop_bit got=%0d exp=0", bit_cnt); end
    // drop cnt_en exactly in the vote cycle: vote completes, counters clear together
    cnt_en = 1'b1; dat_samp_en = 1'b1; rx_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++; if (edge_cnt !== 6'd4) begin bad++; $display("FAIL vote_drop_pre got=%0d exp=4", edge_cnt); end
    cnt_en = 1'b0;
    step();
    total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL vote_drop_valid got=%b exp=1", sample_valid); end
    total++; if (sampled_bit !== 1'b0) begin bad++; $display("FAIL vote_drop_bit got=%b exp=0", sampled_bit); end
    total++; if (edge_cnt !== 6'd0) begin bad++; $display("FAIL vote_drop_edge got=%0d exp=0", edge_cnt); end
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL vote_drop_bitcnt got=%0d exp=0", bit_cnt); end
    go_idle();
  endtask

  task automatic test_reset_mid_vote();
    prescale = 6'd8; rx_in = 1'b0; cnt_en = 1'b1; dat_samp_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    total++; if (edge_cnt !== 6'd4) begin bad++; $display("FAIL rstvote_pre got=%0d exp=4", edge_cnt); end
    rst = 1'b1;
    step();
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rstvote_valid got=%b exp=0", sample_valid); end
    total++; if (sampled_bit !== 1'b1) begin bad++; $display("FAIL rstvote_bit got=%b exp=1", sampled_bit); end
    total++; if (edge_cnt !== 6'd0) begin bad++; $display("FAIL rstvote_edge got=%0d exp=0", edge_cnt); end
    rst = 1'b0;
    step();
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rstvote_after got=%b exp=0", sample_valid); end
    total++; if (edge_cnt !== 6'd1) begin bad++; $display("FAIL rstvote_restart got=%0d exp=1", edge_cnt); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_glitch();
    test_prescale();
    test_enables();
    test_reset_mid_vote();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
